alu_psr_seq: RTL and testbench
==============================

// Module: alu_psr_seq
// PURPOSE
//  Parametrised successor to the 16-bit combinational ALU + 5-flag PSR pair; sits between register-file
//  read and writeback. Merges the ALU and the flag register into one handshaked unit.
//  Adds: generic WIDTH, valid/ready issue, an iterative multiply (multi-cycle FSM), CMP without
//  writeback, per-op flag-update masks, software PSR load, and illegal-opcode detection.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=4)
//  MUL_EN  1   1 = MUL op implemented; 0 = MUL is treated as illegal
// PORTS
//  CLK       in   1      clock, rising edge
//  RESETn    in   1      asynchronous, active-low reset
//  in_valid  in   1      operands and alu_sel are valid this cycle
//  in_ready  out  1      unit can accept; 1 only in state IDLE
//  A, B      in   WIDTH  operands
//  alu_sel   in   7      one-hot op: [6]MUL [5]ADD [4]SUB [3]CMP [2]AND [1]OR [0]XOR
//  out       out  WIDTH  registered result
//  out_valid out  1      1-cycle pulse: out/flag_out updated by a completed op
//  illegal   out  1      1-cycle pulse: accepted alu_sel not one-hot (or MUL with MUL_EN=0)
//  psr_wr    in   1      load PSR from psr_din this cycle
//  psr_din   in   5      PSR load value {F,L,C,N,Z}
//  flag_out  out  5      PSR {F,L,C,N,Z}
// BEHAVIOUR
//  - Reset: out=0, out_valid=0, illegal=0, flag_out=5'b0, state=IDLE, multiply regs=0; effective at once.
//  - Accept = in_valid & in_ready at a rising edge; A/B/alu_sel are captured then and need not be held.
//  - Flags: F signed overflow; L signed A<B; C carry-out (ADD) / borrow (SUB, CMP); N = msb(result);
//    Z = (result==0).
//  - ADD, SUB, CMP: update all five flags. AND, OR, XOR: update N and Z only; F, L, C are held.
//  - CMP: computes A-B for the flags only; out is held.
//  - Single-cycle ops: out and flags are written at the accept edge; out_valid is high the following
//    cycle. Throughput is 1 op/cycle; in_ready stays 1.
//  - MUL (shift-add, 1 bit/cycle): IDLE->MUL at accept; in_ready=0 for WIDTH cycles.
//    out = low WIDTH bits of A*B (unsigned). out_valid pulses WIDTH+1 cycles after the accept edge.
//    MUL updates N and Z from the low half and sets C = (high half != 0); F and L are held.
//    State returns to IDLE on the completing edge.
//  - FSM: IDLE --accept MUL--> MUL --count==WIDTH-1--> IDLE. All other ops stay in IDLE.
//    The iteration counter is $clog2(WIDTH) bits wide.
//  - Illegal alu_sel: accepted, illegal pulses the next cycle, out and flags unchanged, out_valid=0.
//  - psr_wr: flag_out<=psr_din. If it coincides with a flag update from a completing op, psr_wr wins;
//    out still updates and out_valid still pulses.
//  - in_valid while busy: ignored (no accept). The producer must hold in_valid until in_ready.
//  - RESETn asserted mid-MUL: the op is aborted with no out_valid and all reset values apply.
//  - Add/sub arithmetic is WIDTH+1 bits wide; wrap-around is modulo 2^WIDTH.
// STRUCTURE
//  - Shared package alu_pkg: op-bit index localparams (OP_MUL..OP_XOR), FLAG index localparams
//    (FL_F=4, FL_L=3, FL_C=2, FL_N=1, FL_Z=0), FSM state encodings (S_IDLE, S_MUL), and the per-op
//    flag-update mask table.
//  - One sub-module, alu_core: combinational WIDTH-bit ADD/SUB/CMP/logic datapath producing result and
//    the 5 raw flags. MUL iteration, the FSM and the PSR stay in the top level.
// TESTING (WIDTH=16, MUL_EN=1)
//  1. RESETn=0 for 4 cycles, then high -> out=0, flag_out=0, in_ready=1, out_valid=0.
//  2. ADD 46d3+c9ba -> out=108d, flags F0 L0 C1 N0 Z0. Then SUB -> out=7d19, flags F0 L0 C1 N0 Z0.
//  3. Back-to-back ADD 96c4+5d3f (out=f403, N=1, C=0) then AND (out=1404, N=0, Z=0, C stays 0);
//     out_valid high on two consecutive cycles.
//  4. CMP 1234,1234 -> Z=1, C=0, L=0, N=0, F=0; out unchanged (holds prior value).
//  5. MUL 0003*0005 -> in_ready=0 for 16 cycles, out=000f at +17, C=0.
//     MUL 0100*0100 -> out=0000, Z=1, C=1.
//     Assert RESETn=0 mid-MUL -> no out_valid, all outputs 0.
//  6. alu_sel=0000011 -> illegal pulse, flags unchanged.
//     psr_wr with psr_din=10101 on the same edge as an ADD -> flag_out=10101, out=ADD result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/PSR unit: one-hot op bit positions, PSR
// flag bit positions, FSM state encodings and the per-op flag-update masks.
package alu_pkg;

  // alu_sel bit positions (one-hot)
  localparam int OP_W   = 7;
  localparam int OP_MUL = 6;
  localparam int OP_ADD = 5;
  localparam int OP_SUB = 4;
  localparam int OP_CMP = 3;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 1;
  localparam int OP_XOR = 0;

  // PSR bit positions, {F,L,C,N,Z}
  localparam int FL_W = 5;
  localparam int FL_F = 4;
  localparam int FL_L = 3;
  localparam int FL_C = 2;
  localparam int FL_N = 1;
  localparam int FL_Z = 0;

  // FSM state encodings
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  // Flag-update masks: a set bit means the op writes that PSR flag
  localparam logic [FL_W-1:0] MASK_ARITH = 5'b11111;
  localparam logic [FL_W-1:0] MASK_LOGIC = 5'b00011;
  localparam logic [FL_W-1:0] MASK_MUL   = 5'b00111;
  localparam logic [FL_W-1:0] MASK_NONE  = 5'b00000;

  function automatic logic [FL_W-1:0] flag_mask(input logic [OP_W-1:0] sel);
    if (sel[OP_MUL])
      return MASK_MUL;
    else if (sel[OP_ADD] || sel[OP_SUB] || sel[OP_CMP])
      return MASK_ARITH;
    else if (sel[OP_AND] || sel[OP_OR] || sel[OP_XOR])
      return MASK_LOGIC;
    else
      return MASK_NONE;
  endfunction

  function automatic logic sel_onehot(input logic [OP_W-1:0] sel);
    return (sel != '0) && ((sel & (sel - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU datapath (ADD, SUB, CMP, AND, OR, XOR).
// Ports:
//   a, b    : WIDTH-bit operands
//   sel     : one-hot op select, bits [OP_ADD:0] of alu_sel (MUL is not handled here)
//   result  : WIDTH-bit result (for CMP this is A-B, used only for flags)
//   flags   : raw {F,L,C,N,Z} for this result; the caller applies the update mask
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [OP_ADD:0]   sel,
  output logic [WIDTH-1:0]  result,
  output logic [FL_W-1:0]   flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;
  logic           lt;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow out
    diff   = {1'b0, a} - {1'b0, b};
    lt     = $signed(a) < $signed(b);
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    if (sel[OP_ADD]) begin
      result = sum[WIDTH-1:0];
      carry  = sum[WIDTH];
      ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (sel[OP_SUB] || sel[OP_CMP]) begin
      result = diff[WIDTH-1:0];
      carry  = diff[WIDTH];
      ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end else if (sel[OP_AND]) begin
      result = a & b;
    end else if (sel[OP_OR]) begin
      result = a | b;
    end else if (sel[OP_XOR]) begin
      result = a ^ b;
    end
    flags = {ovf, lt, carry, result[WIDTH-1], result == '0};
  end

endmodule

// File: rtl/alu_psr_seq.sv
// Handshaked ALU + PSR unit between register-file read and writeback.
// Single-cycle ops complete at the accept edge; MUL is an iterative
// shift-add multiply taking WIDTH cycles, during which in_ready is low.
// Ports:
//   CLK, RESETn     : clock (rising edge), asynchronous active-low reset
//   in_valid/ready  : issue handshake; ready only in IDLE
//   A, B, alu_sel   : operands and one-hot op, captured at accept
//   out, out_valid  : registered result and 1-cycle completion pulse
//   illegal         : 1-cycle pulse for a non-one-hot (or disabled MUL) op
//   psr_wr, psr_din : software PSR load, overrides any same-edge flag update
//   flag_out        : PSR {F,L,C,N,Z}
module alu_psr_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [OP_W-1:0]   alu_sel,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              illegal,
  input  logic              psr_wr,
  input  logic [FL_W-1:0]   psr_din,
  output logic [FL_W-1:0]   flag_out
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH-1:0] core_result;
  logic [FL_W-1:0]  core_flags;

  logic             accept;
  logic             sel_bad;
  logic             mul_done;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             flag_upd;
  logic [FL_W-1:0]  flag_raw;
  logic [FL_W-1:0]  flag_msk;
  logic [FL_W-1:0]  flag_next;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (B),
    .sel    (alu_sel[OP_ADD:0]),
    .result (core_result),
    .flags  (core_flags)
  );

  assign in_ready = (state == S_IDLE);

  always_comb begin
    accept   = in_valid && in_ready;
    sel_bad  = !sel_onehot(alu_sel) || (alu_sel[OP_MUL] && (MUL_EN == 0));
    // {mul_hi, mul_lo} is the running product; mul_lo's low bit is the
    // next multiplier bit. Each step adds A into the high half and shifts right.
    step_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : '0);
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], mul_lo[WIDTH-1:1]};
    mul_done = (state == S_MUL) && (cnt == LAST);

    flag_upd = 1'b0;
    flag_raw = '0;
    flag_msk = '0;
    if (mul_done) begin
      flag_upd = 1'b1;
      flag_raw = {1'b0, 1'b0, step_hi != '0, step_lo[WIDTH-1], step_lo == '0};
      flag_msk = MASK_MUL;
    end else if (accept && !sel_bad && !alu_sel[OP_MUL]) begin
      flag_upd = 1'b1;
      flag_raw = core_flags;
      flag_msk = flag_mask(alu_sel);
    end
    flag_next = (flag_out & ~flag_msk) | (flag_raw & flag_msk);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mul_a     <= '0;
      mul_hi    <= '0;
      mul_lo    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      flag_out  <= '0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (sel_bad) begin
              illegal <= 1'b1;
            end else if (alu_sel[OP_MUL]) begin
              state  <= S_MUL;
              cnt    <= '0;
              mul_a  <= A;
              mul_hi <= '0;
              mul_lo <= B;
            end else begin
              if (!alu_sel[OP_CMP])
                out <= core_result;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          mul_hi <= step_hi;
          mul_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (mul_done) begin
            out       <= step_lo;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (psr_wr)
        flag_out <= psr_din;
      else if (flag_upd)
        flag_out <= flag_next;
    end
  end

endmodule

// File: tb/tb_alu_psr_seq.sv
// Self-checking bench for alu_psr_seq (WIDTH=16, MUL_EN=1): directed
// scenarios plus a randomized op stream checked against an integer model.
module tb_alu_psr_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [6:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        illegal;
  logic        psr_wr;
  logic [4:0]  psr_din;
  logic [4:0]  flag_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] MUL = 7'b1000000;
  localparam logic [6:0] ADD = 7'b0100000;
  localparam logic [6:0] SUB = 7'b0010000;
  localparam logic [6:0] CMP = 7'b0001000;
  localparam logic [6:0] AND = 7'b0000100;

  alu_psr_seq #(.WIDTH(16), .MUL_EN(1)) dut (
    .CLK       (clk),
    .RESETn    (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .alu_sel   (sel),
    .out       (out),
    .out_valid (out_valid),
    .illegal   (illegal),
    .psr_wr    (psr_wr),
    .psr_din   (psr_din),
    .flag_out  (flag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic on the architectural rules.
  function automatic void ref_op(input logic [6:0] s, input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] cur_out, input logic [4:0] cur_fl,
                                 output logic [15:0] nxt_out, output logic [4:0] nxt_fl,
                                 output bit nxt_valid, output bit nxt_ill);
    int unsigned      ux;
    int unsigned      uy;
    int               sx;
    int               sy;
    int               sr;
    longint unsigned  p;
    logic [15:0]      res;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    nxt_out = cur_out; nxt_fl = cur_fl;
    if ($countones(s) != 1) begin
      nxt_ill = 1'b1; nxt_valid = 1'b0;
      return;
    end
    nxt_ill = 1'b0; nxt_valid = 1'b1;
    if (s[6]) begin
      p = longint'(ux) * longint'(uy);
      res = p[15:0];
      nxt_fl[2] = (p >> 16) != 0;
      nxt_fl[1] = res[15];
      nxt_fl[0] = (res == 16'h0);
      nxt_out = res;
    end else if (s[5] || s[4] || s[3]) begin
      if (s[5]) begin
        res = 16'(ux + uy); sr = sx + sy;
        nxt_fl[2] = (ux + uy) > 65535;
      end else begin
        res = 16'(ux - uy); sr = sx - sy;
        nxt_fl[2] = ux < uy;
      end
      nxt_fl[4] = (sr > 32767) || (sr < -32768);
      nxt_fl[3] = sx < sy;
      nxt_fl[1] = res[15];
      nxt_fl[0] = (res == 16'h0);
      if (!s[3]) nxt_out = res;
    end else begin
      res = s[2] ? (x & y) : (s[1] ? (x | y) : (x ^ y));
      nxt_fl[1] = res[15];
      nxt_fl[0] = (res == 16'h0);
      nxt_out = res;
    end
  endfunction

  // Drive one op; returns once the accept edge has passed (sampled #1 after it).
  task automatic send(input logic [6:0] s, input logic [15:0] x, input logic [15:0] y,
                      input logic wr, input logic [4:0] din, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    sel = s; a = x; b = y; in_valid = 1'b1; psr_wr = wr; psr_din = din;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0; psr_wr = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && !illegal && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; psr_wr = 1'b0; psr_din = '0; a = '0; b = '0; sel = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (out !== 16'h0)      begin failures++; $display("FAIL reset_out got=%h exp=0000", out); end
    checks++; if (flag_out !== 5'b0)  begin failures++; $display("FAIL reset_flags got=%b exp=00000", flag_out); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (illegal !== 1'b0)   begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
  endtask

  task automatic test_add_sub;
    bit ok;
    send(ADD, 16'h46d3, 16'hc9ba, 1'b0, '0, ok);
    checks++; if (out !== 16'h108d)     begin failures++; $display("FAIL add_out got=%h exp=108d", out); end
    checks++; if (flag_out !== 5'b00100) begin failures++; $display("FAIL add_flags got=%b exp=00100", flag_out); end
    checks++; if (out_valid !== 1'b1)   begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    send(SUB, 16'h46d3, 16'hc9ba, 1'b0, '0, ok);
    checks++; if (out !== 16'h7d19)     begin failures++; $display("FAIL sub_out got=%h exp=7d19", out); end
    checks++; if (flag_out !== 5'b00100) begin failures++; $display("FAIL sub_flags got=%b exp=00100", flag_out); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    sel = ADD; a = 16'h96c4; b = 16'h5d3f; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out !== 16'hf403)      begin failures++; $display("FAIL b2b_add_out got=%h exp=f403", out); end
    checks++; if (flag_out !== 5'b01010) begin failures++; $display("FAIL b2b_add_flags got=%b exp=01010", flag_out); end
    checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL b2b_valid1 got=%b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    sel = AND;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out !== 16'h1404)      begin failures++; $display("FAIL b2b_and_out got=%h exp=1404", out); end
    checks++; if (flag_out !== 5'b01000) begin failures++; $display("FAIL b2b_and_flags got=%b exp=01000", flag_out); end
    checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL b2b_valid2 got=%b exp=1", out_valid); end
  endtask

  task automatic test_cmp;
    bit ok;
    send(CMP, 16'h1234, 16'h1234, 1'b0, '0, ok);
    checks++; if (out !== 16'h1404)      begin failures++; $display("FAIL cmp_out_held got=%h exp=1404", out); end
    checks++; if (flag_out !== 5'b00001) begin failures++; $display("FAIL cmp_flags got=%b exp=00001", flag_out); end
  endtask

  task automatic test_mul;
    bit ok;
    int n;
    int busy;
    send(MUL, 16'h0003, 16'h0005, 1'b0, '0, ok);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_early_valid got=%b exp=0", out_valid); end
    n = 0; busy = 0;
    while (!out_valid && n < 40) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 16)               begin failures++; $display("FAIL mul_latency got=%0d exp=16", n); end
    checks++; if (busy != 16)            begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=16", busy); end
    checks++; if (out !== 16'h000f)      begin failures++; $display("FAIL mul_out got=%h exp=000f", out); end
    checks++; if (flag_out !== 5'b00000) begin failures++; $display("FAIL mul_flags got=%b exp=00000", flag_out); end
    checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL mul_ready_after got=%b exp=1", in_ready); end
    send(MUL, 16'h0100, 16'h0100, 1'b0, '0, ok);
    wait_done(n);
    checks++; if (out !== 16'h0000)      begin failures++; $display("FAIL mul2_out got=%h exp=0000", out); end
    checks++; if (flag_out !== 5'b00101) begin failures++; $display("FAIL mul2_flags got=%b exp=00101", flag_out); end
  endtask

  task automatic test_illegal;
    bit ok;
    send(7'b0000011, 16'hffff, 16'h0001, 1'b0, '0, ok);
    checks++; if (illegal !== 1'b1)      begin failures++; $display("FAIL ill_pulse got=%b exp=1", illegal); end
    checks++; if (out_valid !== 1'b0)    begin failures++; $display("FAIL ill_valid got=%b exp=0", out_valid); end
    checks++; if (flag_out !== 5'b00101) begin failures++; $display("FAIL ill_flags got=%b exp=00101", flag_out); end
    checks++; if (out !== 16'h0000)      begin failures++; $display("FAIL ill_out got=%h exp=0000", out); end
    @(posedge clk); #1;
    checks++; if (illegal !== 1'b0)      begin failures++; $display("FAIL ill_one_cycle got=%b exp=0", illegal); end
  endtask

  task automatic test_psr_wr;
    bit ok;
    send(ADD, 16'h0001, 16'h0002, 1'b1, 5'b10101, ok);
    checks++; if (flag_out !== 5'b10101) begin failures++; $display("FAIL psr_flags got=%b exp=10101", flag_out); end
    checks++; if (out !== 16'h0003)      begin failures++; $display("FAIL psr_out got=%h exp=0003", out); end
    checks++; if (out_valid !== 1'b1)    begin failures++; $display("FAIL psr_valid got=%b exp=1", out_valid); end
  endtask

  task automatic test_mul_reset;
    bit ok;
    int seen;
    send(MUL, 16'h0007, 16'h0009, 1'b0, '0, ok);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out !== 16'h0)      begin failures++; $display("FAIL mrst_out got=%h exp=0000", out); end
    checks++; if (flag_out !== 5'b0)  begin failures++; $display("FAIL mrst_flags got=%b exp=00000", flag_out); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL mrst_ready got=%b exp=1", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL mrst_no_valid got=%0d exp=0", seen); end
  endtask

  task automatic test_random;
    logic [15:0] exp_out;
    logic [4:0]  exp_fl;
    logic [15:0] n_out;
    logic [4:0]  n_fl;
    bit          n_valid;
    bit          n_ill;
    logic [6:0]  s;
    logic [15:0] x;
    logic [15:0] y;
    bit          ok;
    int          n;
    exp_out = 16'h0; exp_fl = 5'b0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        s = 7'($urandom);
        if ($countones(s) == 1) s = 7'b0000000;
      end else begin
        s = 7'(1 << $urandom_range(0, 6));
      end
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) y = 16'($urandom_range(0, 3));
      ref_op(s, x, y, exp_out, exp_fl, n_out, n_fl, n_valid, n_ill);
      send(s, x, y, 1'b0, '0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd_accept_timeout i=%0d", i); end
      wait_done(n);
      checks++; if (n != ((s == MUL) ? 16 : 0)) begin failures++; $display("FAIL rnd_latency i=%0d sel=%b got=%0d", i, s, n); end
      checks++; if (out !== n_out) begin failures++; $display("FAIL rnd_out i=%0d sel=%b a=%h b=%h got=%h exp=%h", i, s, x, y, out, n_out); end
      checks++; if (flag_out !== n_fl) begin failures++; $display("FAIL rnd_flags i=%0d sel=%b a=%h b=%h got=%b exp=%b", i, s, x, y, flag_out, n_fl); end
      checks++; if (out_valid !== n_valid || illegal !== n_ill) begin
        failures++; $display("FAIL rnd_pulses i=%0d sel=%b got=%b%b exp=%b%b", i, s, out_valid, illegal, n_valid, n_ill);
      end
      exp_out = n_out; exp_fl = n_fl;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_cmp();
    test_mul();
    test_illegal();
    test_psr_wr();
    test_mul_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
